// File: rtl/memory_cycle_pkg.sv
// Shared types for the MEM stage: FSM states, result-select codes and the MEM/WB payload.
package memory_cycle_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic RES_ALU = 1'b0;
  localparam logic RES_MEM = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } stateT;

  typedef struct packed {
    logic [XLEN-1:0]  aluResult;
    logic [XLEN-1:0]  readData;
    logic [XLEN-1:0]  pcPlus4;
    logic [REG_W-1:0] rd;
    logic             regWrite;
    logic             resultSrc;
  } memWbT;

endpackage

// File: rtl/memory_cycle_data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read, array not reset.
module data_memory
  import memory_cycle_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_cycle.sv
// MEM stage: multi-cycle data memory access with upstream stall, MEM/WB register and result mux.
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RD_M,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  output logic        StallM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RD_W,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [31:0] ResultW
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

  stateT           state, stateNext;
  logic [CW-1:0]   cnt, cntNext;
  logic            memOp;
  logic            stall;
  logic            accessCycle;
  logic            memWe;
  logic [XLEN-1:0] rdata;
  logic            resultSrcEff;
  memWbT           wb;

  assign memOp = MemWriteM | ResultSrcM;

  // A store/load conflict is treated as a store: result comes from the ALU path.
  assign resultSrcEff = MemWriteM ? RES_ALU : ResultSrcM;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    stall       = 1'b0;
    accessCycle = 1'b0;
    if (MEM_LATENCY == 1) begin
      accessCycle = memOp;
    end else begin
      case (state)
        S_IDLE: begin
          if (memOp) begin
            stall     = 1'b1;
            stateNext = S_BUSY;
            cntNext   = CW'(1);
          end
        end
        S_BUSY: begin
          if (cnt < LAST) begin
            stall   = 1'b1;
            cntNext = cnt + CW'(1);
          end else begin
            accessCycle = 1'b1;
            stateNext   = S_IDLE;
            cntNext     = '0;
          end
        end
        default: begin
          stateNext = S_IDLE;
          cntNext   = '0;
        end
      endcase
    end
  end

  // Reset aborts any in-flight access: no stall and no store commit.
  assign StallM = stall & ~rst;
  assign memWe  = accessCycle & MemWriteM & ~rst;

  data_memory #(.DEPTH(DEPTH)) uMem (
    .clk   (clk),
    .we    (memWe),
    .addr  (ALUResultM[2 +: AW]),
    .wdata (WriteDataM),
    .rdata (rdata)
  );

  // Stall cycles insert a bubble: only the write enable is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb <= '0;
    end else if (stall) begin
      wb.regWrite <= 1'b0;
    end else begin
      wb.aluResult <= ALUResultM;
      wb.readData  <= rdata;
      wb.pcPlus4   <= PCPlus4M;
      wb.rd        <= RD_M;
      wb.regWrite  <= RegWriteM;
      wb.resultSrc <= resultSrcEff;
    end
  end

  assign ALUResultW = wb.aluResult;
  assign ReadDataW  = wb.readData;
  assign PCPlus4W   = wb.pcPlus4;
  assign RD_W       = wb.rd;
  assign RegWriteW  = wb.regWrite;
  assign ResultSrcW = wb.resultSrc;
  assign ResultW    = (wb.resultSrc == RES_MEM) ? wb.readData : wb.aluResult;

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: four instances with latencies 1..4 against a word-array reference model.
module tb_memory_cycle;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] aluM [N];
  logic [31:0] wdM  [N];
  logic [31:0] pcM  [N];
  logic [4:0]  rdM  [N];
  logic        rwM  [N];
  logic        mwM  [N];
  logic        rsM  [N];

  logic        stallM [N];
  logic [31:0] aluW   [N];
  logic [31:0] rdatW  [N];
  logic [31:0] pcW    [N];
  logic [4:0]  rdW    [N];
  logic        rwW    [N];
  logic        rsW    [N];
  logic [31:0] resW   [N];

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : gDut
      memory_cycle #(.DEPTH(1024), .MEM_LATENCY(g + 1)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUResultM (aluM[g]),
        .WriteDataM (wdM[g]),
        .PCPlus4M   (pcM[g]),
        .RD_M       (rdM[g]),
        .RegWriteM  (rwM[g]),
        .MemWriteM  (mwM[g]),
        .ResultSrcM (rsM[g]),
        .StallM     (stallM[g]),
        .ALUResultW (aluW[g]),
        .ReadDataW  (rdatW[g]),
        .PCPlus4W   (pcW[g]),
        .RD_W       (rdW[g]),
        .RegWriteW  (rwW[g]),
        .ResultSrcW (rsW[g]),
        .ResultW    (resW[g])
      );
    end
  endgenerate

  int total = 0;
  int bad   = 0;

  // Reference memory: key = instance*1024 + word index.
  logic [31:0] refMem [int];

  function automatic logic [103:0] inSnap(input int k);
    return {aluM[k], wdM[k], pcM[k], rdM[k], rwM[k], mwM[k], rsM[k]};
  endfunction

  // Upstream must hold M inputs while a stall is showing.
  logic [103:0] snapIn    [N];
  logic         snapStall [N];
  logic         snapRst;
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (snapStall[k] === 1'b1 && snapRst === 1'b0 && rst === 1'b0)
        assert (inSnap(k) == snapIn[k]) else $error("inputs changed during stall, instance %0d", k);
      snapIn[k]    <= inSnap(k);
      snapStall[k] <= stallM[k];
    end
    snapRst <= rst;
  end

  task automatic driveIdle(input int k);
    aluM[k] = '0; wdM[k] = '0; pcM[k] = '0; rdM[k] = '0;
    rwM[k] = 1'b0; mwM[k] = 1'b0; rsM[k] = 1'b0;
  endtask

  function automatic int keyOf(input int k, input logic [31:0] addr);
    return k * 1024 + int'((addr >> 2) % 1024);
  endfunction

  // Issue one instruction on instance k and follow it to writeback.
  task automatic doOp(input int k, input bit isStore, input bit isLoad,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] rd, input bit regWr, input string tag);
    int          stalls = 0;
    bit          done   = 0;
    int          key;
    int          expStalls;
    logic [31:0] pc;
    logic [31:0] expRes;
    pc  = $urandom;
    key = keyOf(k, addr);
    aluM[k] = addr; wdM[k] = wdata; pcM[k] = pc; rdM[k] = rd;
    rwM[k] = regWr; mwM[k] = isStore; rsM[k] = isLoad;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stallM[k] === 1'b1) begin
        stalls++;
        @(posedge clk); #1;
        total++;
        if (rwW[k] !== 1'b0) begin
          bad++;
          $display("FAIL %s bubble: RegWriteW=%b required 0", tag, rwW[k]);
        end
      end else begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: still stalled after 20 cycles", tag);
    end
    expStalls = (isStore || isLoad) ? k : 0;
    total++;
    if (stalls != expStalls) begin
      bad++;
      $display("FAIL %s stall count: got %0d required %0d", tag, stalls, expStalls);
    end
    if (done) begin
      if (isLoad && !isStore) expRes = refMem.exists(key) ? refMem[key] : 32'hx;
      else                    expRes = addr;
      total++;
      if (resW[k] !== expRes) begin
        bad++;
        $display("FAIL %s ResultW: got %h required %h", tag, resW[k], expRes);
      end
      total++;
      if (rdW[k] !== rd || rwW[k] !== regWr) begin
        bad++;
        $display("FAIL %s rd/we: got %0d/%b required %0d/%b", tag, rdW[k], rwW[k], rd, regWr);
      end
      total++;
      if (aluW[k] !== addr || pcW[k] !== pc) begin
        bad++;
        $display("FAIL %s alu/pc: got %h/%h required %h/%h", tag, aluW[k], pcW[k], addr, pc);
      end
      if (isLoad && !isStore) begin
        total++;
        if (rsW[k] !== 1'b1 || rdatW[k] !== expRes) begin
          bad++;
          $display("FAIL %s load data: got %b/%h required 1/%h", tag, rsW[k], rdatW[k], expRes);
        end
      end
    end
    if (isStore) refMem[key] = wdata;
  endtask

  task automatic checkZero(input int k, input string tag);
    total++;
    if (stallM[k] !== 1'b0 || aluW[k] !== '0 || rdatW[k] !== '0 || pcW[k] !== '0 ||
        rdW[k] !== '0 || rwW[k] !== 1'b0 || rsW[k] !== 1'b0 || resW[k] !== '0) begin
      bad++;
      $display("FAIL %s inst%0d: stall=%b alu=%h rdat=%h pc=%h rd=%0d we=%b src=%b res=%h required all 0",
               tag, k, stallM[k], aluW[k], rdatW[k], pcW[k], rdW[k], rwW[k], rsW[k], resW[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++) driveIdle(k);
    // A pending store during reset must not raise a stall.
    aluM[1] = 32'h300; wdM[1] = 32'hCAFE; mwM[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (stallM[1] !== 1'b0) begin
        bad++;
        $display("FAIL reset stall: got %b required 0", stallM[1]);
      end
      @(posedge clk);
    end
    #1;
    driveIdle(1);
    rst = 1'b0;
    for (int k = 0; k < N; k++) checkZero(k, "reset");
  endtask

  task automatic test_alu();
    doOp(1, 0, 0, 32'h1234, 32'h0, 5'd5, 1'b1, "alu_l2");
    doOp(0, 0, 0, 32'h1234, 32'h0, 5'd5, 1'b1, "alu_l1");
    doOp(0, 1, 0, 32'h80, 32'hA5A5_0001, 5'd0, 1'b0, "store_l1");
    doOp(0, 0, 1, 32'h80, 32'h0, 5'd9, 1'b1, "load_l1");
    driveIdle(0); driveIdle(1);
  endtask

  task automatic test_store_load();
    doOp(1, 1, 0, 32'h40, 32'hDEAD_BEEF, 5'd0, 1'b0, "store_40");
    doOp(1, 0, 1, 32'h40, 32'h0, 5'd7, 1'b1, "load_40");
    driveIdle(1);
  endtask

  task automatic test_lat4();
    doOp(3, 1, 0, 32'h8, 32'h0BAD_F00D, 5'd0, 1'b0, "store_8");
    doOp(3, 0, 1, 32'h8, 32'h0, 5'd12, 1'b1, "load_8");
    driveIdle(3);
    @(posedge clk); #1;
    total++;
    if (rwW[3] !== 1'b0) begin
      bad++;
      $display("FAIL lat4 single pulse: RegWriteW=%b required 0", rwW[3]);
    end
  endtask

  task automatic test_wrap();
    doOp(1, 1, 0, 32'h1000, 32'h55, 5'd0, 1'b0, "store_1000");
    doOp(1, 0, 1, 32'h0, 32'h0, 5'd3, 1'b1, "load_0");
    doOp(1, 0, 1, 32'h3, 32'h0, 5'd4, 1'b1, "load_3");
    driveIdle(1);
  endtask

  task automatic test_back_to_back();
    doOp(2, 1, 0, 32'h10, 32'h1111_AAAA, 5'd0, 1'b0, "store_10");
    doOp(2, 1, 0, 32'h14, 32'h2222_BBBB, 5'd0, 1'b0, "store_14");
    doOp(2, 0, 1, 32'h10, 32'h0, 5'd1, 1'b1, "load_10");
    doOp(2, 0, 1, 32'h14, 32'h0, 5'd2, 1'b1, "load_14");
    driveIdle(2);
  endtask

  task automatic test_reset_mid_access();
    doOp(3, 1, 0, 32'h20, 32'h1111_1111, 5'd0, 1'b0, "store_20");
    aluM[3] = 32'h20; wdM[3] = 32'hBAD0_BAD0; mwM[3] = 1'b1; rsM[3] = 1'b0; rwM[3] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (stallM[3] !== 1'b1) begin
      bad++;
      $display("FAIL mid-access stall: got %b required 1", stallM[3]);
    end
    rst = 1'b1;
    driveIdle(3);
    repeat (3) begin
      @(negedge clk);
      total++;
      if (stallM[3] !== 1'b0) begin
        bad++;
        $display("FAIL reset-busy stall: got %b required 0", stallM[3]);
      end
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    checkZero(3, "reset_busy");
    doOp(3, 0, 1, 32'h20, 32'h0, 5'd8, 1'b1, "load_after_abort");
    driveIdle(3);
  endtask

  task automatic test_random();
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 25; i++) begin
        int          w;
        int          kind;
        logic [31:0] addr;
        w    = int'($urandom_range(0, 7));
        addr = ($urandom & 32'hFFFF_F000) | (32'h200 + 32'(w) * 32'd4) | ($urandom & 32'h3);
        kind = int'($urandom_range(0, 2));
        if (kind == 2 && !refMem.exists(keyOf(k, addr))) kind = 1;
        case (kind)
          0:       doOp(k, 0, 0, addr, $urandom, 5'($urandom), 1'($urandom), "rnd_alu");
          1:       doOp(k, 1, 0, addr, $urandom, 5'($urandom), 1'b0, "rnd_store");
          default: doOp(k, 0, 1, addr, 32'h0, 5'($urandom), 1'b1, "rnd_load");
        endcase
      end
      driveIdle(k);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_load();
    test_lat4();
    test_wrap();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
